// File: rtl/audio_receiver.sv
// I2S receive deserializer: synchronizes lrck/sck/sdout, captures left/right words and
// presents each stereo pair on a valid/ready holding register. Define AUDIO_RX_PEAK_EN for peak metering.
module audio_receiver #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              audio_lrck,
    input  logic              audio_sck,
    input  logic              audio_sdout,
    input  logic              sample_ready,
    input  logic              overrun_clr,
    output logic              sample_valid,
    output logic [DATA_W-1:0] audio_out_left,
    output logic [DATA_W-1:0] audio_out_right,
    output logic              overrun
`ifdef AUDIO_RX_PEAK_EN
    , output logic [DATA_W-1:0] peak_level
`endif
);

    // state | meaning
    // SYNC  | waiting for an lrck fall to align on a left half-frame
    // LEFT  | capturing left; lrck rise latches left_word
    // RIGHT | capturing right; lrck fall latches right_word and completes the pair
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DATA_W + 1);

    state_t state_q, state_d;
    logic [2:0]        lrck_sync_q, lrck_sync_d;
    logic [2:0]        sck_sync_q, sck_sync_d;
    logic [1:0]        sdout_sync_q, sdout_sync_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] left_word_q, left_word_d;
    logic [DATA_W-1:0] right_word_q, right_word_d;
    logic              pair_done_q, pair_done_d;
    logic [DATA_W-1:0] out_left_q, out_left_d;
    logic [DATA_W-1:0] out_right_q, out_right_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    logic lrck_edge, lrck_rise, lrck_fall, sck_rise, sdout_bit;
    logic latch_left, latch_right, load, drop;

    always_comb begin
        lrck_sync_d  = {lrck_sync_q[1:0], audio_lrck};
        sck_sync_d   = {sck_sync_q[1:0], audio_sck};
        sdout_sync_d = {sdout_sync_q[0], audio_sdout};
        lrck_rise    = lrck_sync_q[1] & ~lrck_sync_q[2];
        lrck_fall    = ~lrck_sync_q[1] & lrck_sync_q[2];
        lrck_edge    = lrck_rise | lrck_fall;
        sck_rise     = sck_sync_q[1] & ~sck_sync_q[2];
        sdout_bit    = sdout_sync_q[1];
    end

    // bit_cnt 0 is the I2S delay bit; counts 1..DATA_W land MSB-first, later bits are ignored
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (lrck_edge) begin
            bit_cnt_d = sck_rise ? CNT_ONE : '0;
            shift_d   = '0;
        end else if (sck_rise) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (bit_cnt_q == CNT_W'(DATA_W - i)) shift_d[i] = sdout_bit;
            end
            if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= SYNC;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SYNC:    if (lrck_fall) state_d = LEFT;
            LEFT:    if (lrck_rise) state_d = RIGHT;
            RIGHT:   if (lrck_fall) state_d = LEFT;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        latch_left  = (state_q == LEFT) && lrck_rise;
        latch_right = (state_q == RIGHT) && lrck_fall;
    end

    always_comb begin
        left_word_d  = latch_left ? shift_q : left_word_q;
        right_word_d = latch_right ? shift_q : right_word_q;
        pair_done_d  = latch_right;
        load         = pair_done_q && (!valid_q || sample_ready);
        drop         = pair_done_q && valid_q && !sample_ready;
        out_left_d   = load ? left_word_q : out_left_q;
        out_right_d  = load ? right_word_q : out_right_q;
        valid_d      = load ? 1'b1 : (sample_ready ? 1'b0 : valid_q);
        overrun_d    = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lrck_sync_q  <= '0;
            sck_sync_q   <= '0;
            sdout_sync_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_word_q  <= '0;
            right_word_q <= '0;
            pair_done_q  <= 1'b0;
            out_left_q   <= '0;
            out_right_q  <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            lrck_sync_q  <= lrck_sync_d;
            sck_sync_q   <= sck_sync_d;
            sdout_sync_q <= sdout_sync_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_word_q  <= left_word_d;
            right_word_q <= right_word_d;
            pair_done_q  <= pair_done_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sample_valid    = valid_q;
    assign audio_out_left  = out_left_q;
    assign audio_out_right = out_right_q;
    assign overrun         = overrun_q;

`ifdef AUDIO_RX_PEAK_EN
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [DATA_W-1:0] abs_left, abs_right;

    // the most negative code has no positive twin, so it clamps to full scale
    function automatic logic [DATA_W-1:0] abs_sat(input logic [DATA_W-1:0] v);
        if (!v[DATA_W-1])                         return v;
        else if (v == {1'b1, {(DATA_W-1){1'b0}}}) return {1'b0, {(DATA_W-1){1'b1}}};
        else                                      return -v;
    endfunction

    always_comb begin
        abs_left  = abs_sat(left_word_q);
        abs_right = abs_sat(right_word_q);
        peak_d    = overrun_clr ? '0 : peak_q;
        if (load) begin
            if (abs_left > peak_d)  peak_d = abs_left;
            if (abs_right > peak_d) peak_d = abs_right;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_audio_receiver.sv
// Scoreboard bench for audio_receiver: drives I2S frames, queues expected pairs, a monitor checks handshakes.
`timescale 1ns/1ps
module tb_audio_receiver;

    localparam int DATA_W   = 16;
    localparam int SCK_HALF = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              audio_lrck = 1'b1;
    logic              audio_sck = 1'b1;
    logic              audio_sdout = 1'b0;
    logic              sample_ready = 1'b1;
    logic              overrun_clr = 1'b0;
    logic              sample_valid;
    logic [DATA_W-1:0] audio_out_left;
    logic [DATA_W-1:0] audio_out_right;
    logic              overrun;
`ifdef AUDIO_RX_PEAK_EN
    logic [DATA_W-1:0] peak_level;
    int                peak_m;
`endif

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    pair_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    pops   = 0;

    audio_receiver dut (
`ifdef AUDIO_RX_PEAK_EN
        .peak_level     (peak_level),
`endif
        .clk            (clk),
        .rst            (rst),
        .audio_lrck     (audio_lrck),
        .audio_sck      (audio_sck),
        .audio_sdout    (audio_sdout),
        .sample_ready   (sample_ready),
        .overrun_clr    (overrun_clr),
        .sample_valid   (sample_valid),
        .audio_out_left (audio_out_left),
        .audio_out_right(audio_out_right),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word: only the bits that fit after the delay bit survive, the rest read as zero.
    function automatic logic [DATA_W-1:0] captured(input logic [DATA_W-1:0] word, input int nsck);
        logic [DATA_W-1:0] all1;
        int kept;
        all1 = '1;
        kept = nsck - 1;
        if (kept >= DATA_W) return word;
        if (kept <= 0) return '0;
        return word & ~(all1 >> kept);
    endfunction

    function automatic int abs_sat(input logic [DATA_W-1:0] v);
        int s;
        s = int'($signed(v));
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    // Each sck period: data changes with sck low, sampled by the DUT on the rise.
    task automatic send_half(input logic lr, input logic [DATA_W-1:0] word, input int nsck);
        for (int j = 0; j < nsck; j++) begin
            audio_lrck = lr;
            audio_sck  = 1'b0;
            if (j >= 1 && j <= DATA_W) audio_sdout = word[DATA_W-j];
            else                       audio_sdout = 1'($urandom);
            repeat (SCK_HALF) @(negedge clk);
            audio_sck = 1'b1;
            repeat (SCK_HALF) @(negedge clk);
        end
    endtask

    task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                             input int nl, input int nr, input bit accept);
        pair_t p;
        p.l = captured(l, nl);
        p.r = captured(r, nr);
        if (accept) exp_q.push_back(p);
        send_half(1'b0, l, nl);
        send_half(1'b1, r, nr);
    endtask

    task automatic close_frame();
        send_half(1'b0, '0, 4);
    endtask

    task automatic start_test();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst = 1'b1;
        sample_ready = 1'b1;
        overrun_clr = 1'b0;
        audio_lrck = 1'b1;
        audio_sck = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Monitor: every accepted handshake must match the oldest expected pair.
    initial begin
        pair_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && sample_valid && sample_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got %h/%h expected none", audio_out_left, audio_out_right);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_left", 32'(audio_out_left), 32'(e.l));
                    chk("pair_right", 32'(audio_out_right), 32'(e.r));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops0;
        logic [DATA_W-1:0] rl, rr;
        int nl, nr;

        @(negedge clk);
        start_test();
        #1;
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_left", 32'(audio_out_left), 32'd0);
        chk("rst_right", 32'(audio_out_right), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);

        // three full frames, always ready
        pops0 = pops;
        for (int k = 0; k < 3; k++) send_pair(16'h1234, 16'hABCD, 32, 32, 1'b1);
        close_frame();
        repeat (10) @(negedge clk);
        #1;
        chk("three_pairs", 32'(pops - pops0), 32'd3);
        chk("no_overrun", 32'(overrun), 32'd0);
        @(negedge clk);

        // reset in the middle of a left half-frame
        start_test();
        send_pair(16'h5A5A, 16'hC3C3, 32, 32, 1'b1);
        fork
            send_half(1'b0, 16'h7777, 32);
            begin
                repeat (60) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("midrst_valid", 32'(sample_valid), 32'd0);
                chk("midrst_left", 32'(audio_out_left), 32'd0);
                chk("midrst_right", 32'(audio_out_right), 32'd0);
            end
        join
        send_half(1'b1, 16'h9999, 32);
        pops0 = pops;
        send_pair(16'h0F0F, 16'hF0F0, 32, 32, 1'b1);
        close_frame();
        repeat (10) @(negedge clk);
        #1;
        chk("midrst_one_pair", 32'(pops - pops0), 32'd1);
        @(negedge clk);

        // short left half-frame: delay bit + 9 data bits
        start_test();
        send_pair(16'hAABB, 16'h1357, 10, 32, 1'b1);
        close_frame();
        repeat (10) @(negedge clk);

        // backpressure over two pairs: first pair held, second dropped
        start_test();
        sample_ready = 1'b0;
        send_pair(16'h1111, 16'h2222, 32, 32, 1'b1);
        send_pair(16'h3333, 16'h4444, 32, 32, 1'b0);
        close_frame();
        repeat (10) @(negedge clk);
        #1;
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(sample_valid), 32'd1);
        chk("ovr_left_held", 32'(audio_out_left), 32'h1111);
        chk("ovr_right_held", 32'(audio_out_right), 32'h2222);
        @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("ovr_sticky", 32'(overrun), 32'd1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        #1;
        chk("ovr_cleared", 32'(overrun), 32'd0);
        @(negedge clk);

        // ready in the same cycle the second pair completes: A handed off, B loaded
        start_test();
        sample_ready = 1'b0;
        send_pair(16'hA0A0, 16'hA1A1, 32, 32, 1'b1);
        send_pair(16'hB0B0, 16'hB1B1, 32, 32, 1'b1);
        fork
            close_frame();
            begin
                repeat (3) @(negedge clk);
                sample_ready = 1'b1;
                @(negedge clk);
                sample_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        #1;
        chk("same_valid", 32'(sample_valid), 32'd1);
        chk("same_left", 32'(audio_out_left), 32'hB0B0);
        chk("same_right", 32'(audio_out_right), 32'hB1B1);
        chk("same_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        sample_ready = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);

        // random words and half-frame lengths
        start_test();
        for (int k = 0; k < 8; k++) begin
            rl = DATA_W'($urandom);
            rr = DATA_W'($urandom);
            nl = int'($urandom_range(1, 34));
            nr = int'($urandom_range(1, 34));
            send_pair(rl, rr, nl, nr, 1'b1);
        end
        close_frame();
        repeat (10) @(negedge clk);
        #1;
        chk("rand_overrun", 32'(overrun), 32'd0);
        @(negedge clk);

`ifdef AUDIO_RX_PEAK_EN
        start_test();
        #1;
        peak_m = 0;
        chk("peak_reset", 32'(peak_level), 32'd0);
        @(negedge clk);
        send_pair(16'h0100, 16'hFE00, 32, 32, 1'b1);
        peak_m = (abs_sat(16'h0100) > abs_sat(16'hFE00)) ? abs_sat(16'h0100) : abs_sat(16'hFE00);
        exp_q.push_back('{16'h8000, 16'h0000});
        send_half(1'b0, 16'h8000, 32);
        #1;
        chk("peak_first", 32'(peak_level), 32'(peak_m));
        @(negedge clk);
        send_half(1'b1, 16'h0000, 32);
        close_frame();
        repeat (10) @(negedge clk);
        if (abs_sat(16'h8000) > peak_m) peak_m = abs_sat(16'h8000);
        #1;
        chk("peak_second", 32'(peak_level), 32'(peak_m));
        @(negedge clk);
`endif

        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
